ysyx_23060203_ifetch: RTL
=========================

# ysyx_23060203_ifetch

PC-generation and fetch-control stage placed directly upstream of the instruction cache. It owns the architectural fetch PC and presents word addresses to the cache. It waits out misses without disturbing an in-flight refill, and hands fetched instructions to decode over a valid/ready handshake. It also applies redirects from execute and sequences `fence.i` invalidation of the cache.

## Interface
Parameters:
- `RESET_PC`, default `32'h3000_0000`: PC after reset.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `redirect_valid` in 1: flush request from execute; one-cycle pulse.
- `redirect_pc` in 32: target PC for the redirect.
- `fencei_req` in 1: `fence.i` committed; only asserted together with `redirect_valid`.
- `icache_addr` out 32: lookup address, always `{pc[31:2],2'b00}`.
- `icache_hit` in 1: combinational hit for `icache_addr`.
- `icache_inst` in 32: instruction word for `icache_addr`, valid when hit.
- `icache_fencei` out 1: invalidate-all pulse to the cache.
- `out_valid` out 1: fetched instruction available.
- `out_ready` in 1: decode accepts.
- `out_pc` out 32: PC of `out_inst`.
- `out_inst` out 32: instruction word; 0 when `out_fault`.
- `out_fault` out 1: instruction-address-misaligned (`out_pc[1:0] != 0`).

## Operation
- **Invariant.** `icache_addr` may change only in a cycle where `icache_hit=1`. The cache latches the refill tag from the live address, so the address must stay stable through a miss.
- **FSM states.** The FSM has three states: `RUN`, `DRAIN`, `FENCE`.
- **`RUN`, no redirect, hit.**
  - Capture when `~out_valid | out_ready`.
  - On capture: load `out_pc=pc`, `out_inst = fault ? 0 : icache_inst`, `out_fault=(pc[1:0]!=0)`, `out_valid=1`; then `pc <= pc+4`.
  - When not capturing, hold `pc`.
- **`RUN`, no redirect, miss.** Hold everything.
- **`RUN` + redirect.**
  - `out_valid <= 0` regardless of `out_ready`, and nothing is captured that cycle.
  - If `icache_hit=1`: `pc <= redirect_pc`; next state is `FENCE` if `fencei_req`, else `RUN`.
  - If `icache_hit=0`: latch `redir_pc`, set `fence_pend=fencei_req`, go to `DRAIN`.
- **`DRAIN`.**
  - Hold `pc` and address; capture nothing.
  - A further redirect overwrites `redir_pc` (youngest wins) and ORs into `fence_pend`.
  - When `icache_hit=1`: discard the word, `pc <= redir_pc`, and go to `FENCE` if `fence_pend`, else `RUN`.
- **`FENCE`.**
  - In the first cycle with `icache_hit=1`, drive `icache_fencei=1` for exactly that cycle, capture nothing, clear `fence_pend`, and go to `RUN`.
  - While `icache_hit=0` (a miss on the new target is in flight), hold and wait.
  - A redirect in `FENCE` updates `pc` only when `icache_hit=1`; otherwise it latches `redir_pc` and the block enters `DRAIN` with `fence_pend` kept set.
- **Output handshake.** If `out_valid & out_ready` and there is no capture, `out_valid <= 0`. Output registers are stable while `out_valid & ~out_ready`.
- **Arithmetic.** `pc+4` wraps modulo 2^32 with no fault; `32'hFFFF_FFFC` is followed by 0.
- **Misaligned PC.** The address is still looked up aligned. The result is flagged as a fault and fetch continues at `pc+4`; the flush comes from execute's trap redirect.

## Timing
- **Reset values.** `pc=RESET_PC`, state `RUN`, `out_valid=0`, `out_pc=0`, `out_inst=0`, `out_fault=0`, `icache_fencei=0`, `fence_pend=0`, `icache_addr=RESET_PC`.
- **Latency.** Hit at cycle t gives `out_valid` at t+1. Steady-state throughput is 1 instruction per cycle while hitting and `out_ready=1`.
- **Redirect.** Redirect in cycle t means `out_valid=0` at t+1 and the first target instruction no earlier than t+2 (hit case).
- **`fence.i`.** A `fence.i` redirect costs at least one extra cycle for the invalidate pulse, then a guaranteed miss.
- **Reset mid-operation.** Reset during a miss returns to the reset state immediately; the cache is reset by the same signal.

## Structure
- Shared package `ysyx_23060203_pkg`:
  - `fetch_state_t` enum (`RUN`, `DRAIN`, `FENCE`), one-hot.
  - `RESET_PC_DEFAULT` constant.
- No sub-module: the single output slot and the FSM are small enough to live inline.

## Test plan
- **Reset.** Release reset, cache always hits, `out_ready=1` → `out_pc` = `30000000`, `30000004`, `30000008` on consecutive cycles; `out_valid=1` from cycle 1.
- **Miss hold.** Hold `icache_hit=0` for 10 cycles at `30000040` → `icache_addr` is constant and `out_valid=0`; on hit, `out_pc=30000040` the next cycle.
- **Redirect during a miss.** Redirect to `80000000` while `icache_hit=0`, then a second redirect to `80000100` → no capture; after the hit, `icache_addr=80000100` and the first `out_pc=80000100`.
- **Backpressure then redirect.** `out_ready=0` for 5 cycles → `out_*` stable and `pc` held; redirect with `out_valid=1` → `out_valid=0` the next cycle, and the held instruction is never accepted.
- **`fence.i`.** `fencei_req` + redirect to `30000204` with hit → exactly one `icache_fencei` pulse while `icache_hit=1`; next `icache_addr=30000204` and the cache reports a miss.
- **Misaligned target.** Redirect to `30000002` → `icache_addr=30000000`; output `out_pc=30000002`, `out_fault=1`, `out_inst=0`; next `pc=30000006`.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// Shared types and constants for the ysyx_23060203 fetch stage.
package ysyx_23060203_pkg;

  // One-hot fetch FSM encoding.
  typedef enum logic [2:0] {
    RUN   = 3'b001,
    DRAIN = 3'b010,
    FENCE = 3'b100
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

  // The cache is always looked up on a word boundary, even for a misaligned PC.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060203_ifetch.sv
// PC generation and fetch control in front of the instruction cache.
// Owns the fetch PC, holds the lookup address steady across misses, applies
// redirects from execute and sequences the fence.i invalidate pulse.
//
// Handshake: out_valid/out_ready follow strict valid/ready rules. A word
// transfers on a clock edge where out_valid & out_ready are both high; while
// out_valid & ~out_ready the out_* registers do not change. A redirect drops
// out_valid unconditionally, so a stalled word is discarded.
module ysyx_23060203_ifetch
  import ysyx_23060203_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fencei_req,
  output logic [31:0] icache_addr,
  input  logic        icache_hit,
  input  logic [31:0] icache_inst,
  output logic        icache_fencei,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic         fence_pend_q, fence_pend_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_inst_q, out_inst_d;
  logic         out_fault_q, out_fault_d;
  logic         fencei;

  // In DRAIN a same-cycle redirect is younger than the latched one and wins.
  logic [31:0]  drain_tgt;
  logic         drain_fence;
  logic         pc_misaligned;

  assign drain_tgt     = redirect_valid ? redirect_pc : redir_pc_q;
  assign drain_fence   = fence_pend_q | (redirect_valid & fencei_req);
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  // Next-state, PC update, output-slot and fence pulse logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    fence_pend_d = fence_pend_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    out_fault_d  = out_fault_q;
    fencei       = 1'b0;

    // A consumed word empties the slot unless a capture refills it below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          if (icache_hit) begin
            pc_d = redirect_pc;
            if (fencei_req) begin
              state_d      = FENCE;
              fence_pend_d = 1'b1;
            end
          end else begin
            // Address must not move during a miss: park the target.
            redir_pc_d   = redirect_pc;
            fence_pend_d = fencei_req;
            state_d      = DRAIN;
          end
        end else if (icache_hit && (!out_valid_q || out_ready)) begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          out_inst_d  = pc_misaligned ? 32'h0 : icache_inst;
          out_fault_d = pc_misaligned;
          pc_d        = pc_q + 32'd4;
        end
      end
      DRAIN: begin
        if (icache_hit) begin
          // The refill for the stale address completed; drop the word.
          pc_d         = drain_tgt;
          fence_pend_d = drain_fence;
          state_d      = drain_fence ? FENCE : RUN;
        end else begin
          redir_pc_d   = drain_tgt;
          fence_pend_d = drain_fence;
        end
      end
      FENCE: begin
        if (icache_hit) begin
          fencei       = 1'b1;
          fence_pend_d = 1'b0;
          state_d      = RUN;
          if (redirect_valid) begin
            pc_d = redirect_pc;
            if (fencei_req) begin
              state_d      = FENCE;
              fence_pend_d = 1'b1;
            end
          end
        end else if (redirect_valid) begin
          redir_pc_d   = redirect_pc;
          fence_pend_d = 1'b1;
          state_d      = DRAIN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end
  end

  // State, PC and output-slot registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      redir_pc_q   <= 32'h0;
      fence_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'h0;
      out_inst_q   <= 32'h0;
      out_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      fence_pend_q <= fence_pend_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      out_fault_q  <= out_fault_d;
    end
  end

  assign icache_addr   = align_word(pc_q);
  assign icache_fencei = fencei;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_inst      = out_inst_q;
  assign out_fault     = out_fault_q;

endmodule
